// File: rtl/ysyx_25020037_scb.sv
// Issue scoreboard between decode and execute: tracks outstanding writes and holds issue on
// load-use hazards, per-register overflow or a full pipeline. YSYX_25020037_SCB_PERF_EN adds stall counters.
module ysyx_25020037_scb #(
    parameter int NREG     = 32,
    parameter int CNT_MAX  = 3,
    parameter int INFLIGHT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [4:0]      issue_rd,
    input  logic            issue_wen,
    input  logic            issue_is_load,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic            issue_use_rs1,
    input  logic            issue_use_rs2,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            wb_wen,
    input  logic            wb_is_load,
    output logic [NREG-1:0] busy_mask,
    output logic [2:0]      inflight_cnt,
    output logic            idle
`ifdef YSYX_25020037_SCB_PERF_EN
    ,
    output logic [31:0]     perf_stall_load,
    output logic [31:0]     perf_stall_full
`endif
);

    localparam logic [1:0] CNT_LIM = 2'(CNT_MAX);
    localparam logic [2:0] INF_LIM = 3'(INFLIGHT);

    logic [1:0]      cnt     [NREG];
    logic [1:0]      cnt_nxt [NREG];
    logic [NREG-1:0] load_pend;
    logic [NREG-1:0] pend_nxt;
    logic [2:0]      inflight;
    logic [2:0]      inflight_nxt;

    logic iss_trk;
    logic wb_trk;
    logic raw1;
    logic raw2;
    logic ovf;
    logic full;
    logic fire;
    logic wb_dec;
    logic infl_dec;

    always_comb begin
        iss_trk     = issue_wen && (issue_rd != 5'd0);
        wb_trk      = wb_wen && (wb_rd != 5'd0);
        raw1        = issue_use_rs1 && (issue_rs1 != 5'd0) && load_pend[issue_rs1];
        raw2        = issue_use_rs2 && (issue_rs2 != 5'd0) && load_pend[issue_rs2];
        ovf         = iss_trk && (cnt[issue_rd] == CNT_LIM);
        full        = (inflight == INF_LIM);
        issue_ready = !flush && !raw1 && !raw2 && !ovf && !full;
        fire        = issue_valid && issue_ready;
        // Underflowing writebacks are ignored so the counters hold at zero.
        wb_dec      = wb_valid && wb_trk && (cnt[wb_rd] != 2'd0);
        infl_dec    = wb_valid && (inflight != 3'd0);
    end

    always_comb begin
        cnt_nxt  = cnt;
        pend_nxt = load_pend;
        if (wb_dec) begin
            cnt_nxt[wb_rd] = cnt[wb_rd] - 2'd1;
            // Older loads to the same register keep it pending until the last one returns.
            if (wb_is_load && (cnt[wb_rd] == 2'd1)) begin
                pend_nxt[wb_rd] = 1'b0;
            end
        end
        // Applied after the writeback so the newest writer decides the pending state.
        if (fire && iss_trk) begin
            cnt_nxt[issue_rd]  = cnt_nxt[issue_rd] + 2'd1;
            pend_nxt[issue_rd] = issue_is_load;
        end
    end

    always_comb begin
        inflight_nxt = inflight;
        case ({fire, infl_dec})
            2'b10:   inflight_nxt = inflight + 3'd1;
            2'b01:   inflight_nxt = inflight - 3'd1;
            default: inflight_nxt = inflight;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= 2'd0;
            end
            load_pend <= '0;
            inflight  <= 3'd0;
        end else begin
            cnt       <= cnt_nxt;
            load_pend <= pend_nxt;
            inflight  <= inflight_nxt;
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_mask[r] = (cnt[r] != 2'd0);
        end
        inflight_cnt = inflight;
        idle         = (inflight == 3'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst && wb_valid && ((inflight == 3'd0) || (wb_trk && (cnt[wb_rd] == 2'd0)))) begin
            $error("scoreboard underflow: writeback rd=%0d with no outstanding write", wb_rd);
        end
    end

`ifdef YSYX_25020037_SCB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_load <= 32'd0;
            perf_stall_full <= 32'd0;
        end else begin
            if (issue_valid && (raw1 || raw2) && !flush) begin
                perf_stall_load <= perf_stall_load + 32'd1;
            end
            if (issue_valid && (full || ovf) && !raw1 && !raw2 && !flush) begin
                perf_stall_full <= perf_stall_full + 32'd1;
            end
        end
    end
`endif

endmodule
